// File: rtl/pla_truth_scanner.sv
// pla_truth_scanner: drives every input vector into a small PAL/PLA cell,
// waits SETTLE cycles per vector, samples the cell output into a truth table
// and compares it against a latched expected table.
// Optional: `define PLA_SCAN_STOP_ON_MISMATCH_EN to end the scan at the first
// mismatching vector instead of sweeping the full table.
module pla_truth_scanner #(
    parameter int N_IN   = 3,
    parameter int SETTLE = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [(1<<N_IN)-1:0]   expected,
    output logic [N_IN-1:0]        abc_out,
    input  logic                   d_in,
    output logic                   busy,
    output logic                   done,
    output logic [(1<<N_IN)-1:0]   table_out,
    output logic                   match,
    output logic [N_IN-1:0]        fail_index
);
    localparam int TW = 1 << N_IN;
    localparam int CW = (SETTLE < 1) ? 1 : $clog2(SETTLE + 1);
    localparam logic [N_IN:0] LAST = (N_IN+1)'(TW - 1);

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    state_t            state, state_n;
    logic [N_IN:0]     idx, idx_n;
    logic [CW-1:0]     cnt, cnt_n;
    logic [TW-1:0]     exp_r, exp_n;
    logic [TW-1:0]     tbl_n, tbl_cap, diff;
    logic [N_IN-1:0]   abc_n, fi_n, low_fi;
    logic              busy_n, done_n, match_n;

    // Table as it would look with the current d_in captured, and the lowest
    // index where that table disagrees with the latched expectation.
    always_comb begin
        tbl_cap = table_out;
        tbl_cap[idx[N_IN-1:0]] = d_in;
        diff   = tbl_cap ^ exp_r;
        low_fi = '0;
        for (int i = TW - 1; i >= 0; i--) begin
            if (diff[i]) low_fi = i[N_IN-1:0];
        end
    end

    // Next-state and next-output logic; every register holds by default.
    always_comb begin
        state_n = state;
        idx_n   = idx;
        cnt_n   = cnt;
        exp_n   = exp_r;
        tbl_n   = table_out;
        abc_n   = abc_out;
        fi_n    = fail_index;
        busy_n  = busy;
        match_n = match;
        done_n  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    exp_n   = expected;
                    idx_n   = '0;
                    abc_n   = '0;
                    cnt_n   = CW'(SETTLE);
                    tbl_n   = '0;
                    match_n = 1'b0;
                    fi_n    = '0;
                    busy_n  = 1'b1;
                    state_n = WAIT;
                end
            end
            WAIT: begin
                if (cnt != '0) begin
                    cnt_n = cnt - CW'(1);
                end else begin
                    tbl_n = tbl_cap;
`ifdef PLA_SCAN_STOP_ON_MISMATCH_EN
                    if (d_in != exp_r[idx[N_IN-1:0]]) begin
                        state_n = DONE;
                        done_n  = 1'b1;
                        match_n = 1'b0;
                        fi_n    = idx[N_IN-1:0];
                    end else
`endif
                    if (idx == LAST) begin
                        // Terminal compare comes before the increment, so
                        // idx never wraps.
                        state_n = DONE;
                        done_n  = 1'b1;
                        match_n = (diff == '0);
                        fi_n    = low_fi;
                    end else begin
                        idx_n = idx + (N_IN+1)'(1);
                        abc_n = idx_n[N_IN-1:0];
                        cnt_n = CW'(SETTLE);
                    end
                end
            end
            DONE: begin
                busy_n  = 1'b0;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // State and output registers; synchronous reset aborts any scan.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            idx        <= '0;
            cnt        <= '0;
            exp_r      <= '0;
            table_out  <= '0;
            abc_out    <= '0;
            fail_index <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            match      <= 1'b0;
        end else begin
            state      <= state_n;
            idx        <= idx_n;
            cnt        <= cnt_n;
            exp_r      <= exp_n;
            table_out  <= tbl_n;
            abc_out    <= abc_n;
            fail_index <= fi_n;
            busy       <= busy_n;
            done       <= done_n;
            match      <= match_n;
        end
    end
endmodule

// File: tb/tb_pla_truth_scanner.sv
// Scoreboard bench for pla_truth_scanner: random cell truth tables and
// expectations, reference result computed from the table rules.
module tb_pla_truth_scanner;
    localparam int S = 2;

    logic       clk = 1'b0, rst_n = 1'b0, start = 1'b0;
    logic [7:0] expected = '0, cell_tt = '0;
    logic [2:0] abc_out, fail_index;
    logic [7:0] table_out;
    logic       d_in, busy, done, match;

    // second instance exercises SETTLE=0
    logic       start0 = 1'b0;
    logic [7:0] expected0 = '0, cell0 = 8'h96;
    logic [2:0] abc0, fi0;
    logic [7:0] tbl0;
    logic       d0, busy0, done0, match0;

    int cyc = 0, n_chk = 0, n_err = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign d_in = cell_tt[abc_out];
    assign d0   = cell0[abc0];

    pla_truth_scanner #(.N_IN(3), .SETTLE(S)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .expected(expected),
        .abc_out(abc_out), .d_in(d_in), .busy(busy), .done(done),
        .table_out(table_out), .match(match), .fail_index(fail_index));

    pla_truth_scanner #(.N_IN(3), .SETTLE(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .expected(expected0),
        .abc_out(abc0), .d_in(d0), .busy(busy0), .done(done0),
        .table_out(tbl0), .match(match0), .fail_index(fi0));

    typedef struct {
        logic [7:0] tbl;
        logic       m;
        int         fi;
        int         lat;
        int         sc;
    } exp_t;
    exp_t q[$];

    task automatic chk(input string nm, input int act, input int req);
        n_chk++;
        if (act != req) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h (cyc %0d)", nm, act, req, cyc);
        end
    endtask

    // Reference: the cell is a fixed truth table during a scan.
    function automatic exp_t model(input logic [7:0] tt, input logic [7:0] ex,
                                   input int sc, input int settle);
        exp_t r;
        int   first;
        first = -1;
        for (int i = 0; i < 8; i++)
            if (first < 0 && tt[i] != ex[i]) first = i;
        r.sc  = sc;
        r.m   = (first < 0);
        r.fi  = (first < 0) ? 0 : first;
        r.tbl = tt;
        r.lat = 8 * (settle + 1);
`ifdef PLA_SCAN_STOP_ON_MISMATCH_EN
        if (first >= 0) begin
            r.tbl = '0;
            for (int i = 0; i <= first; i++) r.tbl[i] = tt[i];
            r.lat = (first + 1) * (settle + 1);
        end
`endif
        return r;
    endfunction

    // Monitor: checks the vector sequence during a scan and the result at done.
    always @(negedge clk) begin : mon
        int e;
        if (rst_n) begin
            if (q.size() > 0 && cyc >= q[0].sc) begin
                e = cyc - q[0].sc;
                if (e < q[0].lat) begin
                    chk("abc_step", int'(abc_out), e / (S + 1));
                    chk("busy_scan", int'(busy), 1);
                    if (done) chk("early_done", e, q[0].lat);
                end else begin
                    chk("done_lat", int'(done), 1);
                    chk("table", int'(table_out), int'(q[0].tbl));
                    chk("match", int'(match), int'(q[0].m));
                    chk("fail_idx", int'(fail_index), q[0].fi);
                    chk("busy_done", int'(busy), 1);
                    void'(q.pop_front());
                end
            end else if (done) begin
                chk("spurious_done", int'(done), 0);
            end
        end
    end

    // Caller sits at a negedge with the DUT idle.
    task automatic start_scan(input logic [7:0] tt, input logic [7:0] ex);
        cell_tt  = tt;
        expected = ex;
        start    = 1'b1;
        q.push_back(model(tt, ex, cyc + 1, S));
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) chk("timeout", n, 0);
        chk("sb_drained", q.size(), 0);
    endtask

    task automatic chk_reset_outs(input string nm);
        chk({nm, "_abc"}, int'(abc_out), 0);
        chk({nm, "_busy"}, int'(busy), 0);
        chk({nm, "_done"}, int'(done), 0);
        chk({nm, "_table"}, int'(table_out), 0);
        chk({nm, "_match"}, int'(match), 0);
        chk({nm, "_fi"}, int'(fail_index), 0);
    endtask

    task automatic scan0(input logic [7:0] ex, input logic [7:0] t_req,
                         input logic m_req, input int fi_req, input int lat_req);
        int n;
        expected0 = ex;
        start0    = 1'b1;
        @(posedge clk);
        n = 0;
        @(negedge clk);
        start0 = 1'b0;
        while (!done0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("s0_lat", n, lat_req);
        chk("s0_table", int'(tbl0), int'(t_req));
        chk("s0_match", int'(match0), int'(m_req));
        chk("s0_fi", int'(fi0), fi_req);
        @(negedge clk);
        chk("s0_idle", int'(busy0), 0);
    endtask

    initial begin
        logic [7:0] tt, ex;
        int n;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_reset_outs("rst");
        rst_n = 1'b1;
        n = 0;
        repeat (6) begin
            @(negedge clk);
            if (busy || done) n++;
        end
        chk("idle_quiet", n, 0);

        // (a&b)|c -> 8'hEA
        start_scan(8'hEA, 8'hEA);
        wait_idle();
        start_scan(8'hEA, 8'hE8);
        wait_idle();

        // restart while busy and expected change must be ignored
        start_scan(8'hEA, 8'hEA);
        repeat (9) @(negedge clk);
        start = 1'b1;
        expected = 8'h00;
        @(negedge clk);
        start = 1'b0;
        wait_idle();
        repeat (3) @(negedge clk);
        chk("held_table", int'(table_out), 8'hEA);
        chk("held_abc", int'(abc_out), 7);

        // reset during vector 4
        start_scan(8'hEA, 8'hEA);
        n = 0;
        while (abc_out != 3'd4 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("reach_vec4", int'(abc_out), 4);
        rst_n = 1'b0;
        @(negedge clk);
        chk_reset_outs("midrst");
        q.delete();
        rst_n = 1'b1;
        @(negedge clk);
        start_scan(8'hEA, 8'hEA);
        wait_idle();

        // random cells, expectation either exact or with some bits flipped
        repeat (20) begin
            tt = 8'($urandom);
            ex = tt;
            if ($urandom_range(0, 1) == 1) ex = tt ^ 8'($urandom_range(1, 255));
            start_scan(tt, ex);
            wait_idle();
        end

        // SETTLE=0: a^b^c; match, and a mismatch only on the last vector
        scan0(8'h96, 8'h96, 1'b1, 0, 8);
        scan0(8'h16, 8'h96, 1'b0, 7, 8);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/pla_truth_scanner.md
Name: pla_truth_scanner

Overview:
- Upstream/downstream neighbour of the 3-input PAL/PLA logic cell (inputs a,b,c; output d).
- Sweeps every input combination into the cell, waits a programmable settle time, then samples its output.
- Assembles the sampled values into a truth-table word and compares it against an expected word.
- Used as on-chip self-check and bench driver for PAL/PLA implementations.

Parameters:
- N_IN, 3, number of cell inputs; table width is 2**N_IN.
- SETTLE, 2, wait cycles after driving a vector before sampling d_in (0 allowed).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset.
- start  input  1  begin scan; sampled only in IDLE.
- expected  input  2**N_IN  expected truth table; bit i = output for input vector i.
- abc_out  output  N_IN  vector driven to the cell; MSB = a, LSB = c for N_IN=3.
- d_in  input  1  cell output d.
- busy  output  1  high from the cycle after start is accepted until DONE is left.
- done  output  1  one-cycle pulse when the result is valid.
- table_out  output  2**N_IN  captured truth table.
- match  output  1  table_out == latched expected; valid from done, held until next start.
- fail_index  output  N_IN  lowest mismatching vector index; 0 when match=1.

Behaviour:
- Reset (rst_n=0 at a clk edge): state=IDLE; abc_out=0, busy=0, done=0, table_out=0, match=0, fail_index=0; index and settle counter cleared.
- Reset mid-scan aborts immediately to this same state; no partial result is reported.
- States: IDLE, WAIT, DONE.
- IDLE, start=1:
  - latch expected into exp_r; index=0; abc_out=0; cnt=SETTLE; table_out=0; busy=1; go to WAIT.
- WAIT, cnt!=0: cnt-- .
- WAIT, cnt==0:
  - table_out[index]=d_in.
  - If index==2**N_IN-1: go to DONE.
  - Otherwise: index++, abc_out=index+1, cnt=SETTLE.
- Timing:
  - Each vector holds abc_out for exactly SETTLE+1 cycles.
  - Full scan = 2**N_IN*(SETTLE+1) cycles from the start edge to DONE entry.
- DONE (one cycle):
  - done=1; match=(table_out==exp_r); fail_index=lowest i with table_out[i]!=exp_r[i], or 0.
  - busy=0 and state=IDLE next cycle.
- Outputs are held after completion:
  - abc_out holds the last vector.
  - table_out, match and fail_index hold until the next accepted start.
- Input/busy rules:
  - start while busy or in DONE is ignored (no queuing).
  - start held high re-triggers one cycle after DONE.
  - expected changes during a scan have no effect; only the latched copy is used.
- Index/counter widths:
  - index is N_IN+1 bits internally; no wrap occurs because the terminal compare precedes the increment.
  - The settle counter is sized clog2(SETTLE+1), minimum 1 bit.
- All outputs are registered; no combinational path from d_in to any output.

Optional Feature:
- Macro: PLA_SCAN_STOP_ON_MISMATCH_EN.
- Defined:
  - In WAIT with cnt==0, if d_in != exp_r[index], capture the bit, set fail_index=index, and go directly to DONE.
  - match=0; table_out bits above index remain 0.
- Undefined:
  - The full table is always scanned.
  - fail_index is computed at DONE as described above.

Test Plan:
- Reset/idle: hold rst_n=0 3 cycles, then release with start=0 -> all outputs 0, busy=0 indefinitely.
- Pass case: SETTLE=2, cell d=(a&b)|c, expected=8'hEA, pulse start -> abc_out steps 0..7, each held 3 cycles; done pulses 24 cycles after the start edge; table_out=8'hEA, match=1, fail_index=0.
- Fail case: same cell, expected=8'hE8 -> table_out=8'hEA, match=0, fail_index=1. With PLA_SCAN_STOP_ON_MISMATCH_EN: done after 6 cycles, table_out=8'h02, fail_index=1.
- Ignored start: pulse start again at cycle 10 of a scan, and change expected -> scan timing and result unchanged; only one done pulse.
- Reset mid-scan: assert rst_n=0 during vector 4 -> next cycle all outputs 0, state IDLE; a new start yields a correct full scan.
- SETTLE=0: d=a^b^c, expected=8'h96 -> one vector per cycle, done 8 cycles after start, match=1.
